// File: rtl/min_max_pkg.sv
// Shared definitions for the min/max array loader and its finder.
// Holds the array geometry and the one-hot control state encoding.
package min_max_pkg;

    localparam int unsigned MM_WIDTH = 8;
    localparam int unsigned MM_DEPTH = 16;
    localparam int unsigned MM_AW    = $clog2(MM_DEPTH);

    // One-hot encoding; bit order matches the {Qd,Qw,Qs,Ql,Qi} flag bus.
    typedef enum logic [4:0] {
        INI   = 5'b00001,
        LOAD  = 5'b00010,
        START = 5'b00100,
        WAIT  = 5'b01000,
        DONE  = 5'b10000
    } state_t;

endpackage

// File: rtl/array_mem_16x8.sv
// Element array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module array_mem_16x8 #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             We,
    input  logic [AW-1:0]    Waddr,
    input  logic [WIDTH-1:0] Wdata,
    input  logic [AW-1:0]    Raddr,
    output logic [WIDTH-1:0] Rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (We) begin
            mem[Waddr] <= Wdata;
        end
    end

    // A same-cycle write to Raddr becomes visible only after the edge.
    assign Rdata = mem[Raddr];

endmodule

// File: rtl/min_max_array_loader.sv
// Loads DEPTH elements into the array, kicks off the min/max finder,
// and registers its results when it reports done.
module min_max_array_loader #(
    parameter int unsigned WIDTH = min_max_pkg::MM_WIDTH,
    parameter int unsigned DEPTH = min_max_pkg::MM_DEPTH
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Go,
    input  logic                     In_valid,
    input  logic [WIDTH-1:0]         In_data,
    output logic                     In_ready,
    input  logic [$clog2(DEPTH)-1:0] Rd_addr,
    output logic [WIDTH-1:0]         Rd_data,
    output logic                     Find_start,
    input  logic                     Find_done,
    input  logic [WIDTH-1:0]         Max_in,
    input  logic [WIDTH-1:0]         Min_in,
    output logic [WIDTH-1:0]         Max_out,
    output logic [WIDTH-1:0]         Min_out,
    output logic                     Result_valid,
    output logic                     Qi,
    output logic                     Ql,
    output logic                     Qs,
    output logic                     Qw,
    output logic                     Qd
);

    import min_max_pkg::*;

    localparam int unsigned    AW   = $clog2(DEPTH);
    localparam logic [AW-1:0]  LAST = AW'(DEPTH - 1);

    state_t        state, next_state;
    logic [AW-1:0] cnt;
    logic          wr_en;

    assign wr_en = (state == LOAD) && In_valid;

    array_mem_16x8 #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .Clk   (Clk),
        .We    (wr_en),
        .Waddr (cnt),
        .Wdata (In_data),
        .Raddr (Rd_addr),
        .Rdata (Rd_data)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= INI;
            cnt     <= '0;
            Max_out <= '0;
            Min_out <= '0;
        end else begin
            state <= next_state;
            unique case (state)
                INI: begin
                    if (Go) begin
                        cnt <= '0;
                    end
                end
                LOAD: begin
                    // Counter wraps to zero on the last handshake.
                    if (In_valid) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (Find_done) begin
                        Max_out <= Max_in;
                        Min_out <= Min_in;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state   = state;
        In_ready     = 1'b0;
        Find_start   = 1'b0;
        Result_valid = 1'b0;
        unique case (state)
            INI: begin
                if (Go) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                In_ready = 1'b1;
                if (In_valid && (cnt == LAST)) begin
                    next_state = START;
                end
            end
            START: begin
                Find_start = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                if (Find_done) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                Result_valid = 1'b1;
                next_state   = INI;
            end
            default: next_state = INI;
        endcase
    end

    assign {Qd, Qw, Qs, Ql, Qi} = state;

endmodule

// File: tb/tb_min_max_array_loader.sv
// Directed, table-driven bench for min_max_array_loader with a
// hand-driven finder model on the Find_* / Max_in / Min_in ports.
module tb_min_max_array_loader;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Go;
    logic       In_valid;
    logic [7:0] In_data;
    logic       In_ready;
    logic [3:0] Rd_addr;
    logic [7:0] Rd_data;
    logic       Find_start;
    logic       Find_done;
    logic [7:0] Max_in, Min_in;
    logic [7:0] Max_out, Min_out;
    logic       Result_valid;
    logic       Qi, Ql, Qs, Qw, Qd;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [4:0] S_INI   = 5'b00001;
    localparam logic [4:0] S_LOAD  = 5'b00010;
    localparam logic [4:0] S_START = 5'b00100;
    localparam logic [4:0] S_WAIT  = 5'b01000;
    localparam logic [4:0] S_DONE  = 5'b10000;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       exp_ready;
        logic [4:0] exp_state;
    } load_vec_t;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] exp_data;
    } rd_vec_t;

    load_vec_t  lv [32];
    rd_vec_t    rv [16];
    logic [7:0] gap [16];

    min_max_array_loader #(
        .WIDTH (8),
        .DEPTH (16)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Go           (Go),
        .In_valid     (In_valid),
        .In_data      (In_data),
        .In_ready     (In_ready),
        .Rd_addr      (Rd_addr),
        .Rd_data      (Rd_data),
        .Find_start   (Find_start),
        .Find_done    (Find_done),
        .Max_in       (Max_in),
        .Min_in       (Min_in),
        .Max_out      (Max_out),
        .Min_out      (Min_out),
        .Result_valid (Result_valid),
        .Qi           (Qi),
        .Ql           (Ql),
        .Qs           (Qs),
        .Qw           (Qw),
        .Qd           (Qd)
    );

    always #5 Clk = ~Clk;

    function automatic logic [4:0] flags();
        return {Qd, Qw, Qs, Ql, Qi};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        gap = '{8'h05, 8'hFA, 8'h00, 8'h3C, 8'h81, 8'hC7, 8'h12, 8'h9E,
                8'h44, 8'hF9, 8'h01, 8'h6B, 8'hD0, 8'h27, 8'h88, 8'h55};
        for (int k = 0; k < 16; k++) begin
            lv[2*k]   = '{valid: 1'b0, data: 8'hEE,   exp_ready: 1'b1, exp_state: S_LOAD};
            lv[2*k+1] = '{valid: 1'b1, data: gap[k], exp_ready: 1'b1, exp_state: S_LOAD};
            rv[k]     = '{addr: 4'(k), exp_data: gap[k]};
        end

        Reset = 1'b1; Go = 1'b0; In_valid = 1'b0; In_data = '0; Rd_addr = '0;
        Find_done = 1'b0; Max_in = '0; Min_in = '0;

        // Reset state
        #2;
        check("reset_state", flags(), S_INI);
        check("reset_ready", In_ready, 1'b0);
        check("reset_fstart", Find_start, 1'b0);
        check("reset_rvalid", Result_valid, 1'b0);
        check("reset_max", Max_out, 8'h00);
        check("reset_min", Min_out, 8'h00);
        tick();
        tick();
        Reset = 1'b0;

        // Back-to-back load of 0x10..0x1F
        tick();
        check("b2b_ini_ready", In_ready, 1'b0);
        Go = 1'b1;
        tick();
        Go = 1'b0;
        for (int i = 0; i < 16; i++) begin
            In_valid = 1'b1;
            In_data  = 8'(8'h10 + i);
            check("b2b_ready", In_ready, 1'b1);
            check("b2b_no_fstart", Find_start, 1'b0);
            tick();
        end
        In_valid = 1'b0;
        check("b2b_start_state", flags(), S_START);
        check("b2b_fstart", Find_start, 1'b1);
        check("b2b_ready_off", In_ready, 1'b0);
        tick();
        check("b2b_wait_state", flags(), S_WAIT);
        check("b2b_fstart_once", Find_start, 1'b0);
        Find_done = 1'b1; Max_in = 8'h1F; Min_in = 8'h10;
        tick();
        Find_done = 1'b0;
        check("b2b_done_state", flags(), S_DONE);
        check("b2b_rvalid", Result_valid, 1'b1);
        check("b2b_max", Max_out, 8'h1F);
        check("b2b_min", Min_out, 8'h10);
        tick();
        check("b2b_back_ini", flags(), S_INI);
        check("b2b_rvalid_off", Result_valid, 1'b0);
        Rd_addr = 4'd0;  #1 check("b2b_rd0", Rd_data, 8'h10);
        Rd_addr = 4'd15; #1 check("b2b_rd15", Rd_data, 8'h1F);

        // Gapped load, with Find_done held high throughout LOAD
        tick();
        Go = 1'b1;
        tick();
        Go = 1'b0;
        Find_done = 1'b1; Max_in = 8'h77; Min_in = 8'h66;
        for (int i = 0; i < 32; i++) begin
            In_valid = lv[i].valid;
            In_data  = lv[i].data;
            check("gap_ready", In_ready, lv[i].exp_ready);
            check("gap_state", flags(), lv[i].exp_state);
            tick();
        end
        Find_done = 1'b0; In_valid = 1'b0;
        check("gap_start", Find_start, 1'b1);
        check("gap_no_capture_load", Max_out, 8'h1F);

        // Go / In_valid in WAIT must be ignored
        for (int w = 0; w < 6; w++) begin
            tick();
            Go = 1'b1; In_valid = 1'b1; In_data = 8'h99; Max_in = 8'h99; Min_in = 8'h99;
            check("wait_hold_state", flags(), S_WAIT);
            check("wait_no_capture", Max_out, 8'h1F);
        end
        Go = 1'b0; In_valid = 1'b0;
        Find_done = 1'b1; Max_in = 8'hFA; Min_in = 8'h00;
        tick();
        Find_done = 1'b0; Max_in = 8'h11; Min_in = 8'h22;
        check("gap_done_state", flags(), S_DONE);
        check("gap_rvalid", Result_valid, 1'b1);
        check("gap_max", Max_out, 8'hFA);
        check("gap_min", Min_out, 8'h00);
        tick();
        check("gap_back_ini", flags(), S_INI);
        check("gap_hold_max", Max_out, 8'hFA);
        for (int i = 0; i < 16; i++) begin
            Rd_addr = rv[i].addr;
            #1 check("gap_readback", Rd_data, rv[i].exp_data);
        end

        // Reset mid-load after 9 handshakes (addresses 0..8 = k*0x11)
        tick();
        Go = 1'b1;
        tick();
        Go = 1'b0;
        for (int i = 0; i < 9; i++) begin
            In_valid = 1'b1;
            In_data  = 8'(i * 8'h11);
            tick();
        end
        In_valid = 1'b0;
        #2 Reset = 1'b1;
        #1;
        check("midrst_qi", Qi, 1'b1);
        check("midrst_ql", Ql, 1'b0);
        check("midrst_ready", In_ready, 1'b0);
        check("midrst_max", Max_out, 8'h00);
        check("midrst_min", Min_out, 8'h00);
        tick();
        Reset = 1'b0;
        tick();
        Go = 1'b1;
        tick();
        Go = 1'b0;

        // Reload from address 0; element 3 exercises read-during-write
        for (int i = 0; i < 16; i++) begin
            In_valid = 1'b1;
            In_data  = (i < 3) ? 8'(8'h5A + i) : (i == 3) ? 8'h44 : 8'(8'h60 + i);
            if (i == 3) begin
                Rd_addr = 4'd3;
                #1 check("rdw_old", Rd_data, 8'h33);
            end
            tick();
            if (i == 3) begin
                check("rdw_new", Rd_data, 8'h44);
            end
            if (i == 0) begin
                Rd_addr = 4'd0; #1 check("reload_addr0", Rd_data, 8'h5A);
                Rd_addr = 4'd9; #1 check("reload_addr9_kept", Rd_data, 8'hF9);
                Rd_addr = 4'd1; #1 check("reload_addr1_old", Rd_data, 8'h11);
            end
        end
        In_valid = 1'b0;
        check("reload_start", Find_start, 1'b1);
        tick();
        Find_done = 1'b1; Max_in = 8'h6F; Min_in = 8'h44;
        tick();
        Find_done = 1'b0;
        check("reload_rvalid", Result_valid, 1'b1);
        check("reload_max", Max_out, 8'h6F);
        check("reload_min", Min_out, 8'h44);
        tick();
        check("reload_back_ini", flags(), S_INI);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
